// File: rtl/instr_dispatcher.sv
// Instruction dispatcher. Accepts one instruction per cycle and routes it to a
// per-core output slot. Target priority: forced index, load/store steering to
// the LSU core, dependency on a core's recent destinations, then round-robin.
module instr_dispatcher #(
  parameter int NUM_CORES  = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter int HIST_DEPTH = 8,
  parameter int LSU_CORE   = 0
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [DATA_W-1:0]           in_instr_i,
  output logic [NUM_CORES-1:0]        out_valid_o,
  input  logic [NUM_CORES-1:0]        out_ready_i,
  output logic [NUM_CORES*DATA_W-1:0] out_instr_o,
  output logic [15:0]                 stall_count_o
);

  localparam int CW = $clog2(NUM_CORES);
  localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
  localparam logic [2:0] OP_LD  = 3'b111;
  localparam logic [2:0] OP_STR = 3'b110;

  logic [2:0]        opcode;
  logic              force_bit;
  logic [3:0]        fidx;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dest;

  logic [NUM_CORES-1:0] out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    slot_q [NUM_CORES];
  logic [DATA_W-1:0]    slot_d [NUM_CORES];
  logic [ADDR_W-1:0]    hist_q [NUM_CORES][HIST_DEPTH];
  logic [ADDR_W-1:0]    hist_d [NUM_CORES][HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hvld_q [NUM_CORES];
  logic [HIST_DEPTH-1:0] hvld_d [NUM_CORES];
  logic [HW-1:0]        wr_ptr_q [NUM_CORES];
  logic [HW-1:0]        wr_ptr_d [NUM_CORES];
  logic [CW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [15:0]          stall_q, stall_d;

  logic [CW-1:0] tgt;
  logic [CW-1:0] dep_core;
  logic          dep_hit;
  logic          sel_rr;
  logic          accept;

  assign opcode    = in_instr_i[31:29];
  assign force_bit = in_instr_i[28];
  assign fidx      = in_instr_i[27:24];
  assign mode      = in_instr_i[23:22];
  assign src       = in_instr_i[11 +: ADDR_W];
  assign dest      = in_instr_i[0 +: ADDR_W];

  // Target selection; the dependency search runs high-to-low so the lowest
  // matching core is the one left in dep_core.
  always_comb begin
    dep_hit  = 1'b0;
    dep_core = '0;
    for (int c = NUM_CORES - 1; c >= 0; c--) begin
      for (int e = 0; e < HIST_DEPTH; e++) begin
        if (hvld_q[c][e] && (hist_q[c][e] == src)) begin
          dep_hit  = 1'b1;
          dep_core = CW'(c);
        end
      end
    end
    sel_rr = 1'b0;
    tgt    = rr_ptr_q;
    if (force_bit && (32'(fidx) < NUM_CORES)) begin
      tgt = fidx[CW-1:0];
    end else if ((opcode == OP_LD) || (opcode == OP_STR)) begin
      tgt = CW'(LSU_CORE);
    end else if ((mode == 2'b00) && dep_hit) begin
      tgt = dep_core;
    end else begin
      tgt    = rr_ptr_q;
      sel_rr = 1'b1;
    end
  end

  assign in_ready_o = ~out_valid_q[tgt] | out_ready_i[tgt];
  assign accept     = in_valid_i & in_ready_o;

  // Next-state for slots, histories, round-robin pointer and stall counter.
  always_comb begin
    out_valid_d = out_valid_q;
    slot_d      = slot_q;
    hist_d      = hist_q;
    hvld_d      = hvld_q;
    wr_ptr_d    = wr_ptr_q;
    rr_ptr_d    = rr_ptr_q;
    stall_d     = stall_q;

    for (int k = 0; k < NUM_CORES; k++) begin
      if (out_ready_i[k]) out_valid_d[k] = 1'b0;
    end

    if (accept) begin
      out_valid_d[tgt]             = 1'b1;
      slot_d[tgt]                  = in_instr_i;
      hist_d[tgt][wr_ptr_q[tgt]]   = dest;
      hvld_d[tgt][wr_ptr_q[tgt]]   = 1'b1;
      wr_ptr_d[tgt]                = wr_ptr_q[tgt] + HW'(1);
      if (sel_rr) begin
        rr_ptr_d = (32'(rr_ptr_q) == NUM_CORES - 1) ? '0 : rr_ptr_q + CW'(1);
      end
    end

    // Flush wins over the history/pointer update of a same-cycle accept.
    if (flush_i) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        hvld_d[k]   = '0;
        wr_ptr_d[k] = '0;
      end
      rr_ptr_d = '0;
    end

    if (in_valid_i && !in_ready_o && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q <= '0;
      rr_ptr_q    <= '0;
      stall_q     <= '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        slot_q[k]   <= '0;
        hvld_q[k]   <= '0;
        wr_ptr_q[k] <= '0;
        for (int e = 0; e < HIST_DEPTH; e++) hist_q[k][e] <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      stall_q     <= stall_d;
      slot_q      <= slot_d;
      hvld_q      <= hvld_d;
      wr_ptr_q    <= wr_ptr_d;
      hist_q      <= hist_d;
    end
  end

  // Pack slot registers onto the flat output bus.
  always_comb begin
    out_instr_o = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      out_instr_o[k*DATA_W +: DATA_W] = slot_q[k];
    end
  end

  assign out_valid_o   = out_valid_q;
  assign stall_count_o = stall_q;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Bench for instr_dispatcher (2 cores): per-core scoreboard queues checked as
// slots drain, plus direct checks of routing, stalls, flush and reset.
module tb_instr_dispatcher;

  localparam int NC = 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [31:0]   in_instr_i;
  logic [NC-1:0] out_valid_o;
  logic [NC-1:0] out_ready_i;
  logic [NC*32-1:0] out_instr_o;
  logic [15:0]   stall_count_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [31:0] expq [NC][$];

  instr_dispatcher dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_instr_i    (in_instr_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_instr_o   (out_instr_o),
    .stall_count_o (stall_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drain monitor: a slot that is valid and ready leaves at the next edge.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      for (int k = 0; k < NC; k++) begin
        if (out_valid_o[k] && out_ready_i[k]) begin
          if (expq[k].size() == 0) chk($sformatf("spurious_c%0d", k), 32'(out_valid_o[k]), 32'd0);
          else chk($sformatf("drain_c%0d", k), out_instr_o[k*32 +: 32], expq[k].pop_front());
        end
      end
    end
  end

  // Present one instruction, wait (bounded) for acceptance, check the slot.
  task automatic send(input logic [31:0] instr, input int core, output int waits);
    bit ok;
    waits = 0;
    ok = 0;
    in_valid_i = 1'b1;
    in_instr_i = instr;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_i);
      if (in_ready_o) ok = 1;
      else waits++;
    end
    if (!ok) begin
      chk("ready_timeout", 32'(in_ready_o), 32'd1);
      in_valid_i = 1'b0;
    end else begin
      expq[core].push_back(instr);
      @(posedge clk_i);
      #1;
      in_valid_i = 1'b0;
      chk($sformatf("valid_c%0d_%h", core, instr), 32'(out_valid_o[core]), 32'd1);
      chk($sformatf("data_c%0d_%h", core, instr), out_instr_o[core*32 +: 32], instr);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  int w;

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
    in_instr_i = '0; out_ready_i = '1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_instr", out_instr_o[31:0] | out_instr_o[63:32], 32'd0);
    chk("rst_stall", 32'(stall_count_o), 32'd0);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i); #1;

    // Round-robin alternation with mode=01.
    send(32'h0040_0001, 0, w);
    send(32'h0040_0002, 1, w);
    send(32'h0040_0003, 0, w);
    send(32'h0040_0004, 1, w);
    chk("rr_stall", 32'(stall_count_o), 32'd0);

    // Forced routing; out-of-range force falls through to round-robin.
    send(32'h1100_0000, 1, w);
    send(32'h1540_0000, 0, w);
    idle(2);

    // Load stalls behind a full core-0 slot for three cycles.
    out_ready_i = 2'b10;
    send(32'h1000_0007, 0, w);
    fork
      send(32'hE000_0000, 0, w);
      begin
        repeat (3) @(posedge clk_i);
        #1 out_ready_i = 2'b11;
      end
    join
    chk("ld_waits", 32'(w), 32'd3);
    chk("ld_stall", 32'(stall_count_o), 32'd3);
    idle(2);

    // Dependency routing and rr_ptr left untouched (rr_ptr is 1 here).
    send(32'h1100_0005, 1, w);
    send(32'h0000_2810, 1, w);
    send(32'h0040_0011, 1, w);
    for (int i = 0; i < 8; i++) send(32'h1100_0020 + 32'(i), 1, w);
    send(32'h0000_2830, 0, w);
    idle(2);

    // Flush alongside an accept: data delivered, history write dropped.
    flush_i = 1'b1;
    send(32'h0040_000A, 1, w);
    flush_i = 1'b0;
    send(32'h0000_5040, 0, w);
    idle(3);
    chk("q0_empty", 32'(expq[0].size()), 32'd0);
    chk("q1_empty", 32'(expq[1].size()), 32'd0);

    // Reset while both slots are full and the input is stalling.
    out_ready_i = 2'b00;
    send(32'h1000_0001, 0, w);
    send(32'h1100_0002, 1, w);
    in_valid_i = 1'b1;
    in_instr_i = 32'h1000_0003;
    repeat (2) @(posedge clk_i);
    #2;
    chk("pre_rst_valid", 32'(out_valid_o), 32'd3);
    chk("pre_rst_stall", 32'(stall_count_o), 32'd5);
    reset_i = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid_o), 32'd0);
    chk("async_rst_stall", 32'(stall_count_o), 32'd0);
    chk("async_rst_data", out_instr_o[31:0] | out_instr_o[63:32], 32'd0);
    in_valid_i = 1'b0;
    expq[0].delete();
    expq[1].delete();
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i); #1;
    chk("post_rst_ready", 32'(in_ready_o), 32'd1);
    chk("post_rst_valid", 32'(out_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
